// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scanner.
package scan_pkg;

   localparam int unsigned CH_W   = 3;
   localparam int unsigned NUM_CH = 8;

   typedef logic [CH_W-1:0] ch_idx_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

endpackage : scan_pkg

// File: rtl/channel_scan_seq_if.sv
// Control/status bundle between a scan controller and channel_scan_seq.
interface channel_scan_seq_if
   import scan_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
);

   logic                start;
   logic                stop;
   logic [DWELL_W-1:0]  dwell;
   logic [NUM_CH-1:0]   ch_mask;
   ch_idx_t             sel;
   logic                sel_valid;
   logic                busy;
   logic                wrap;

   modport master (
      output start, stop, dwell, ch_mask,
      input  sel, sel_valid, busy, wrap
   );

   modport slave (
      input  start, stop, dwell, ch_mask,
      output sel, sel_valid, busy, wrap
   );

endinterface : channel_scan_seq_if

// File: rtl/next_ch_finder.sv
// Combinational search for the next enabled channel after i_cur, cyclically,
// with i_cur itself as the last candidate.
module next_ch_finder
   import scan_pkg::*;
(
   input  ch_idx_t           i_cur,
   input  logic [NUM_CH-1:0] i_mask,
   output ch_idx_t           o_nxt_c,
   output logic              o_found_c,
   output logic              o_wrapped_c
);

   ch_idx_t           w_base;
   ch_idx_t           w_off;
   logic [NUM_CH-1:0] w_rot;

   // Rotate so the search origin sits at bit 0, priority-encode, then un-rotate.
   always_comb begin
      w_base = i_cur + ch_idx_t'(1);
      w_rot  = '0;
      w_off  = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         w_rot[i] = i_mask[w_base + ch_idx_t'(i)];
      end
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = ch_idx_t'(i);
         end
      end
   end

   assign o_nxt_c     = w_base + w_off;
   assign o_found_c   = |i_mask;
   assign o_wrapped_c = (o_nxt_c <= i_cur);

endmodule : next_ch_finder

// File: rtl/channel_scan_seq.sv
// Cyclic channel scanner: visits enabled channels in ascending order, holding
// each for dwell+1 cycles, and pulses wrap whenever the index does not increase.
module channel_scan_seq
   import scan_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   channel_scan_seq_if.slave  bus
);

   scan_state_t        r_state;
   ch_idx_t            r_sel;
   logic               r_sel_valid;
   logic               r_busy;
   logic               r_wrap;
   logic [DWELL_W-1:0] r_cnt;

   ch_idx_t            w_cur;
   ch_idx_t            w_nxt;
   logic               w_found;
   logic               w_wrapped;

   // In IDLE the search origin is the top channel so the first load lands on the lowest set bit.
   assign w_cur = (r_state == IDLE) ? ch_idx_t'(NUM_CH - 1) : r_sel;

   next_ch_finder u_finder (
      .i_cur       (w_cur),
      .i_mask      (bus.ch_mask),
      .o_nxt_c     (w_nxt),
      .o_found_c   (w_found),
      .o_wrapped_c (w_wrapped)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_sel_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_wrap      <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_wrap <= 1'b0;
               if (bus.start && !bus.stop && w_found) begin
                  r_state     <= SCAN;
                  r_sel       <= w_nxt;
                  r_cnt       <= bus.dwell;
                  r_sel_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end else begin
                  r_sel       <= '0;
                  r_sel_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            SCAN: begin
               if (bus.stop || (r_cnt == '0 && !w_found)) begin
                  r_state     <= IDLE;
                  r_sel       <= '0;
                  r_sel_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_wrap      <= 1'b0;
                  r_cnt       <= '0;
               end else if (r_cnt != '0) begin
                  r_cnt  <= r_cnt - DWELL_W'(1);
                  r_wrap <= 1'b0;
               end else begin
                  r_sel  <= w_nxt;
                  r_cnt  <= bus.dwell;
                  r_wrap <= w_wrapped;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_sel       <= '0;
               r_sel_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_wrap      <= 1'b0;
               r_cnt       <= '0;
            end
         endcase
      end
   end

   assign bus.sel       = r_sel;
   assign bus.sel_valid = r_sel_valid;
   assign bus.busy      = r_busy;
   assign bus.wrap      = r_wrap;

endmodule : channel_scan_seq

// File: tb/tb_channel_scan_seq.sv
// Self-checking bench for channel_scan_seq: vector table plus hand-written
// multi-cycle sequences, all checked through an expected-output queue.
module tb_channel_scan_seq;
   import scan_pkg::*;

   localparam int unsigned DWELL_W = 8;

   typedef struct packed {
      logic [2:0] sel;
      logic       valid;
      logic       busy;
      logic       wrap;
   } exp_t;

   typedef struct {
      logic               start;
      logic               stop;
      logic [DWELL_W-1:0] dwell;
      logic [7:0]         mask;
      exp_t               exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];
   vec_t vecs[17];

   channel_scan_seq_if #(.DWELL_W(DWELL_W)) bus ();

   channel_scan_seq #(.DWELL_W(DWELL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t cur_out();
      return '{sel: bus.sel, valid: bus.sel_valid, busy: bus.busy, wrap: bus.wrap};
   endfunction

   task automatic check(input string name, input exp_t got, input exp_t want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got sel=%0d valid=%0b busy=%0b wrap=%0b, want sel=%0d valid=%0b busy=%0b wrap=%0b",
                  name, got.sel, got.valid, got.busy, got.wrap,
                  want.sel, want.valid, want.busy, want.wrap);
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, compare after the edge.
   task automatic apply(input string name, input logic st, input logic sp,
                        input logic [DWELL_W-1:0] dw, input logic [7:0] mk, input exp_t e);
      exp_t want;
      bus.start   = st;
      bus.stop    = sp;
      bus.dwell   = dw;
      bus.ch_mask = mk;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         want = sb.pop_front();
         check(name, cur_out(), want);
      end
   endtask

   function automatic exp_t full_scan_exp(input int k, input int d);
      exp_t e;
      e.sel   = 3'(((k - 1) / (d + 1)) % 8);
      e.valid = 1'b1;
      e.busy  = 1'b1;
      e.wrap  = (k > 1) && (((k - 1) % (d + 1)) == 0) && (e.sel == 3'd0);
      return e;
   endfunction

   localparam exp_t ZERO = '{sel: 3'd0, valid: 1'b0, busy: 1'b0, wrap: 1'b0};

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b1;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.dwell   = '0;
      bus.ch_mask = '0;

      // Sparse mask, stop, start+stop, empty mask, single channel, mask cleared mid-dwell.
      vecs[0]  = '{1'b1, 1'b0, 8'd0, 8'hA4, '{3'd2, 1'b1, 1'b1, 1'b0}};
      vecs[1]  = '{1'b0, 1'b0, 8'd0, 8'hA4, '{3'd5, 1'b1, 1'b1, 1'b0}};
      vecs[2]  = '{1'b0, 1'b0, 8'd0, 8'hA4, '{3'd7, 1'b1, 1'b1, 1'b0}};
      vecs[3]  = '{1'b0, 1'b0, 8'd0, 8'hA4, '{3'd2, 1'b1, 1'b1, 1'b1}};
      vecs[4]  = '{1'b0, 1'b0, 8'd0, 8'hA4, '{3'd5, 1'b1, 1'b1, 1'b0}};
      vecs[5]  = '{1'b0, 1'b0, 8'd0, 8'hA4, '{3'd7, 1'b1, 1'b1, 1'b0}};
      vecs[6]  = '{1'b0, 1'b0, 8'd0, 8'hA4, '{3'd2, 1'b1, 1'b1, 1'b1}};
      vecs[7]  = '{1'b0, 1'b1, 8'd0, 8'hA4, ZERO};
      vecs[8]  = '{1'b1, 1'b1, 8'd0, 8'hFF, ZERO};
      vecs[9]  = '{1'b1, 1'b0, 8'd0, 8'h00, ZERO};
      vecs[10] = '{1'b1, 1'b0, 8'd1, 8'h10, '{3'd4, 1'b1, 1'b1, 1'b0}};
      vecs[11] = '{1'b0, 1'b0, 8'd1, 8'h10, '{3'd4, 1'b1, 1'b1, 1'b0}};
      vecs[12] = '{1'b0, 1'b0, 8'd1, 8'h10, '{3'd4, 1'b1, 1'b1, 1'b1}};
      vecs[13] = '{1'b1, 1'b0, 8'd1, 8'h10, '{3'd4, 1'b1, 1'b1, 1'b0}};
      vecs[14] = '{1'b0, 1'b0, 8'd1, 8'h10, '{3'd4, 1'b1, 1'b1, 1'b1}};
      vecs[15] = '{1'b0, 1'b0, 8'd1, 8'h00, '{3'd4, 1'b1, 1'b1, 1'b0}};
      vecs[16] = '{1'b0, 1'b0, 8'd1, 8'h00, ZERO};

      // Power-on reset, asynchronous: checked before any clock edge.
      #1 rst_n = 1'b0;
      #1 check("reset_async", cur_out(), ZERO);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) apply("idle_after_reset", 1'b0, 1'b0, 8'd0, 8'hFF, ZERO);

      // Full mask, dwell=2: each channel held 3 cycles, wrap only when 0 returns.
      apply("full_start", 1'b1, 1'b0, 8'd2, 8'hFF, full_scan_exp(1, 2));
      for (int k = 2; k <= 27; k++) apply("full_scan", 1'b0, 1'b0, 8'd2, 8'hFF, full_scan_exp(k, 2));
      apply("full_stop", 1'b0, 1'b1, 8'd2, 8'hFF, ZERO);

      for (int i = 0; i < 17; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].start, vecs[i].stop, vecs[i].dwell,
               vecs[i].mask, vecs[i].exp);
      end

      // Stop on the third cycle of channel 1 with dwell=5.
      apply("stop_start", 1'b1, 1'b0, 8'd5, 8'hFF, full_scan_exp(1, 5));
      for (int k = 2; k <= 9; k++) apply("stop_scan", 1'b0, 1'b0, 8'd5, 8'hFF, full_scan_exp(k, 5));
      apply("stop_ch1", 1'b0, 1'b1, 8'd5, 8'hFF, ZERO);
      apply("stop_hold", 1'b0, 1'b0, 8'd5, 8'hFF, ZERO);

      // Async reset mid-dwell at channel 6, then restart from channel 0.
      apply("rst_start", 1'b1, 1'b0, 8'd3, 8'hFF, full_scan_exp(1, 3));
      for (int k = 2; k <= 26; k++) apply("rst_scan", 1'b0, 1'b0, 8'd3, 8'hFF, full_scan_exp(k, 3));
      #2 rst_n = 1'b0;
      #1 check("reset_mid_scan", cur_out(), ZERO);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) apply("idle_after_rst", 1'b0, 1'b0, 8'd3, 8'hFF, ZERO);
      apply("restart", 1'b1, 1'b0, 8'd3, 8'hFF, full_scan_exp(1, 3));
      for (int k = 2; k <= 6; k++) apply("restart_scan", 1'b0, 1'b0, 8'd3, 8'hFF, full_scan_exp(k, 3));

      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_channel_scan_seq
